// File: rtl/wu_rd_arbiter_if.sv
// Bus bundle between the work-unit array, the read arbiter and ddr_iface.
// master = arbiter view; slave = the requester/ddr_iface environment.
interface wu_rd_arbiter_if #(
    parameter int N_UNITS   = 4,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 64
);
    // requester side
    logic [N_UNITS-1:0]           i_rdata_req;
    logic [N_UNITS*ADDR_BITS-1:0] i_raddr;
    logic [N_UNITS-1:0]           o_rdata_req_accepted;
    logic [DATA_BITS-1:0]         o_rdata;
    logic [N_UNITS-1:0]           o_rdata_valid;

    // ddr_iface side
    logic                         o_rdata_req;
    logic [ADDR_BITS-1:0]         o_raddr;
    logic                         i_rdata_req_accepted;
    logic [DATA_BITS-1:0]         i_rdata;
    logic                         i_rdata_valid;
    logic                         i_rdata_lastword;

    modport master (
        input  i_rdata_req, i_raddr, i_rdata_req_accepted,
               i_rdata, i_rdata_valid, i_rdata_lastword,
        output o_rdata_req_accepted, o_rdata, o_rdata_valid,
               o_rdata_req, o_raddr
    );

    modport slave (
        output i_rdata_req, i_raddr, i_rdata_req_accepted,
               i_rdata, i_rdata_valid, i_rdata_lastword,
        input  o_rdata_req_accepted, o_rdata, o_rdata_valid,
               o_rdata_req, o_raddr
    );
endinterface

// File: rtl/wu_rd_arbiter.sv
// Round-robin, credit-limited arbiter for the shared DDR read port; an in-order tag
// FIFO steers returning bursts to their owners. Optional stall counter: WU_RD_ARB_STATS_EN.
module wu_rd_arbiter #(
    parameter int N_UNITS   = 4,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 64,
    parameter int MAX_OUT   = 4
) (
    input  logic                  i_clk300,
    input  logic                  i_reset,
    wu_rd_arbiter_if.master       bus,
    output logic                  o_err,
    output logic [31:0]           o_stall_cycles
);
    localparam int IDX_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       gnt_q, gnt_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]       outstanding_q, outstanding_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]       tag_mem_q [MAX_OUT];
    logic [IDX_W-1:0]       tag_mem_d [MAX_OUT];
    logic                   req_q, req_d;
    logic [ADDR_BITS-1:0]   raddr_q, raddr_d;
    logic [N_UNITS-1:0]     acc_q, acc_d;
    logic [N_UNITS-1:0]     vld_q, vld_d;
    logic [DATA_BITS-1:0]   rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic                   has_credit;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   found;
    logic [IDX_W-1:0]       pick;
    logic [IDX_W:0]         cand;

    // The FIFO occupancy is exactly the in-flight burst count.
    assign has_credit = (outstanding_q < CNT_W'(MAX_OUT));
    assign fifo_empty = (outstanding_q == '0);
    assign push       = (state_q == ISSUE) && bus.i_rdata_req_accepted;
    assign pop        = bus.i_rdata_valid && bus.i_rdata_lastword && !fifo_empty;

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        cand  = '0;
        for (int k = 0; k < N_UNITS; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (cand >= (IDX_W+1)'(N_UNITS))
                cand = cand - (IDX_W+1)'(N_UNITS);
            if (!found && bus.i_rdata_req[cand[IDX_W-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        rr_ptr_d = rr_ptr_q;
        req_d    = req_q;
        raddr_d  = raddr_q;
        acc_d    = '0;
        case (state_q)
            IDLE: begin
                if (has_credit && found) begin
                    gnt_d   = pick;
                    raddr_d = bus.i_raddr[pick*ADDR_BITS +: ADDR_BITS];
                    req_d   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.i_rdata_req_accepted) begin
                    req_d        = 1'b0;
                    acc_d[gnt_q] = 1'b1;
                    rr_ptr_d     = (gnt_q == IDX_W'(N_UNITS-1)) ? '0 : gnt_q + 1'b1;
                    state_d      = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Tag FIFO and return-path steering.
    always_comb begin
        tag_mem_d     = tag_mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        outstanding_d = outstanding_q;
        vld_d         = '0;
        rdata_d       = rdata_q;
        err_d         = err_q;
        if (push) begin
            tag_mem_d[wr_ptr_q] = gnt_q;
            wr_ptr_d            = wr_ptr_q + 1'b1;
        end
        if (bus.i_rdata_valid) begin
            if (fifo_empty) begin
                err_d = 1'b1;
            end else begin
                rdata_d                    = bus.i_rdata;
                vld_d[tag_mem_q[rd_ptr_q]] = 1'b1;
            end
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge i_clk300) begin
        if (i_reset) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            rr_ptr_q      <= '0;
            outstanding_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            for (int i = 0; i < MAX_OUT; i++)
                tag_mem_q[i] <= '0;
            req_q         <= 1'b0;
            raddr_q       <= '0;
            acc_q         <= '0;
            vld_q         <= '0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            rr_ptr_q      <= rr_ptr_d;
            outstanding_q <= outstanding_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            tag_mem_q     <= tag_mem_d;
            req_q         <= req_d;
            raddr_q       <= raddr_d;
            acc_q         <= acc_d;
            vld_q         <= vld_d;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
        end
    end

    assign bus.o_rdata_req          = req_q;
    assign bus.o_raddr              = raddr_q;
    assign bus.o_rdata_req_accepted = acc_q;
    assign bus.o_rdata_valid        = vld_q;
    assign bus.o_rdata              = rdata_q;
    assign o_err                    = err_q;

`ifdef WU_RD_ARB_STATS_EN
    logic [31:0] stall_q, stall_d;

    // Cycles lost to credit exhaustion while someone is waiting; saturating.
    always_comb begin
        stall_d = stall_q;
        if (|bus.i_rdata_req && (state_q == IDLE) && !has_credit && (stall_q != 32'hFFFF_FFFF))
            stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge i_clk300) begin
        if (i_reset) stall_q <= '0;
        else         stall_q <= stall_d;
    end

    assign o_stall_cycles = stall_q;
`else
    assign o_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_wu_rd_arbiter.sv
// Directed bench for wu_rd_arbiter: reset, single burst, fairness, credit limit,
// return ordering, empty-FIFO error and mid-operation reset.
module tb_wu_rd_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MO = 4;
`ifdef WU_RD_ARB_STATS_EN
    localparam int STALL_EXP = 8;
`else
    localparam int STALL_EXP = 0;
`endif

    logic        clk;
    logic        rst;
    logic        err;
    logic [31:0] stall;
    int          checks   = 0;
    int          failures = 0;

    wu_rd_arbiter_if #(.N_UNITS(N), .ADDR_BITS(AW), .DATA_BITS(DW)) bus();

    wu_rd_arbiter #(.N_UNITS(N), .ADDR_BITS(AW), .DATA_BITS(DW), .MAX_OUT(MO)) dut (
        .i_clk300       (clk),
        .i_reset        (rst),
        .bus            (bus),
        .o_err          (err),
        .o_stall_cycles (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_rdata_req          = '0;
        bus.i_raddr              = '0;
        bus.i_rdata_req_accepted = 1'b0;
        bus.i_rdata              = '0;
        bus.i_rdata_valid        = 1'b0;
        bus.i_rdata_lastword     = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        checks++; if (bus.o_rdata_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b want=0", bus.o_rdata_req); end
        checks++; if (bus.o_raddr !== '0) begin failures++; $display("FAIL reset_raddr got=%h want=0", bus.o_raddr); end
        checks++; if (bus.o_rdata_req_accepted !== '0) begin failures++; $display("FAIL reset_acc got=%b want=0", bus.o_rdata_req_accepted); end
        checks++; if (bus.o_rdata_valid !== '0) begin failures++; $display("FAIL reset_vld got=%b want=0", bus.o_rdata_valid); end
        checks++; if (bus.o_rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h want=0", bus.o_rdata); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b want=0", err); end
        checks++; if (stall !== 32'd0) begin failures++; $display("FAIL reset_stall got=%0d want=0", stall); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        bus.i_raddr[2*AW +: AW] = AW'(32'h123);
        bus.i_rdata_req = 4'b0100;
        step();
        checks++; if (bus.o_rdata_req !== 1'b1) begin failures++; $display("FAIL single_req_rise got=%0b want=1", bus.o_rdata_req); end
        checks++; if (bus.o_raddr !== AW'(32'h123)) begin failures++; $display("FAIL single_raddr got=%h want=123", bus.o_raddr); end
        step();
        checks++; if (bus.o_rdata_req !== 1'b1) begin failures++; $display("FAIL single_req_hold got=%0b want=1", bus.o_rdata_req); end
        checks++; if (bus.o_rdata_req_accepted !== 4'b0000) begin failures++; $display("FAIL single_acc_early got=%b want=0000", bus.o_rdata_req_accepted); end
        bus.i_rdata_req_accepted = 1'b1;
        step();
        checks++; if (bus.o_rdata_req !== 1'b0) begin failures++; $display("FAIL single_req_drop got=%0b want=0", bus.o_rdata_req); end
        checks++; if (bus.o_rdata_req_accepted !== 4'b0100) begin failures++; $display("FAIL single_acc got=%b want=0100", bus.o_rdata_req_accepted); end
        bus.i_rdata_req_accepted = 1'b0;
        bus.i_rdata_req = '0;
        step();
        checks++; if (bus.o_rdata_req_accepted !== 4'b0000) begin failures++; $display("FAIL single_acc_pulse got=%b want=0000", bus.o_rdata_req_accepted); end
        for (int w = 0; w < 4; w++) begin
            bus.i_rdata_valid    = 1'b1;
            bus.i_rdata          = DW'(64'hA0 + w);
            bus.i_rdata_lastword = (w == 3);
            step();
            checks++; if (bus.o_rdata_valid !== 4'b0100) begin failures++; $display("FAIL single_vld w%0d got=%b want=0100", w, bus.o_rdata_valid); end
            checks++; if (bus.o_rdata !== DW'(64'hA0 + w)) begin failures++; $display("FAIL single_rdata w%0d got=%h want=%h", w, bus.o_rdata, 64'hA0 + w); end
        end
        bus.i_rdata_valid    = 1'b0;
        bus.i_rdata_lastword = 1'b0;
        step();
        checks++; if (bus.o_rdata_valid !== 4'b0000) begin failures++; $display("FAIL single_vld_end got=%b want=0000", bus.o_rdata_valid); end
        checks++; if (dut.outstanding_q !== '0) begin failures++; $display("FAIL single_outstanding got=%0d want=0", dut.outstanding_q); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err got=%0b want=0", err); end
    endtask

    task automatic test_fairness();
        logic [N-1:0] g [5];
        int           gc [5];
        int           n = 0;
        logic         pend = 1'b0;
        logic [N-1:0] exp_oh = '0;
        logic [N-1:0] one = 1;
        do_reset();
        for (int u = 0; u < N; u++) bus.i_raddr[u*AW +: AW] = AW'(32'h1000 + u);
        bus.i_rdata_req = '1;
        bus.i_rdata_req_accepted = 1'b1;
        for (int c = 1; c <= 40 && n < 5; c++) begin
            bus.i_rdata_valid    = pend;
            bus.i_rdata_lastword = pend;
            bus.i_rdata          = DW'(c);
            step();
            if (pend) begin
                checks++; if (bus.o_rdata_valid !== exp_oh) begin failures++; $display("FAIL fair_ret c%0d got=%b want=%b", c, bus.o_rdata_valid, exp_oh); end
            end
            pend = 1'b0;
            if (bus.o_rdata_req_accepted !== '0) begin
                g[n]   = bus.o_rdata_req_accepted;
                gc[n]  = c;
                exp_oh = bus.o_rdata_req_accepted;
                pend   = 1'b1;
                n++;
            end
        end
        clear_inputs();
        checks++; if (n != 5) begin failures++; $display("FAIL fair_timeout grants=%0d want=5", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (g[i] !== (one << (i % N))) begin failures++; $display("FAIL fair_order #%0d got=%b want=%b", i, g[i], one << (i % N)); end
            if (i > 0) begin
                checks++; if (gc[i] - gc[i-1] != 3) begin failures++; $display("FAIL fair_spacing #%0d got=%0d want=3", i, gc[i] - gc[i-1]); end
            end
        end
        step();
        step();
    endtask

    task automatic test_credit();
        int           exp_c [5] = '{2, 5, 8, 11, 22};
        logic [N-1:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [N-1:0] g [5];
        int           gc [5];
        int           n = 0;
        logic         blocked_bad = 1'b0;
        do_reset();
        bus.i_rdata_req = '1;
        bus.i_rdata_req_accepted = 1'b1;
        bus.i_rdata = DW'(64'hBEEF);
        for (int c = 1; c <= 22; c++) begin
            bus.i_rdata_valid    = (c == 20);
            bus.i_rdata_lastword = (c == 20);
            step();
            if (c == 20) begin
                checks++; if (bus.o_rdata_valid !== 4'b0001) begin failures++; $display("FAIL credit_ret_vld got=%b want=0001", bus.o_rdata_valid); end
                checks++; if (bus.o_rdata !== DW'(64'hBEEF)) begin failures++; $display("FAIL credit_ret_data got=%h want=beef", bus.o_rdata); end
            end
            if (c >= 13 && c <= 20 && bus.o_rdata_req !== 1'b0) blocked_bad = 1'b1;
            if (bus.o_rdata_req_accepted !== '0) begin
                if (n < 5) begin
                    g[n]  = bus.o_rdata_req_accepted;
                    gc[n] = c;
                end
                n++;
            end
        end
        checks++; if (n != 5) begin failures++; $display("FAIL credit_grants got=%0d want=5", n); end
        for (int i = 0; i < 5 && i < n; i++) begin
            checks++; if (g[i] !== exp_g[i] || gc[i] != exp_c[i]) begin failures++; $display("FAIL credit_grant #%0d got=%b@%0d want=%b@%0d", i, g[i], gc[i], exp_g[i], exp_c[i]); end
        end
        checks++; if (blocked_bad !== 1'b0) begin failures++; $display("FAIL credit_blocked got=req_while_full want=no_req"); end
        checks++; if (stall !== 32'(STALL_EXP)) begin failures++; $display("FAIL credit_stall got=%0d want=%0d", stall, STALL_EXP); end
        clear_inputs();
    endtask

    task automatic test_order();
        do_reset();
        bus.i_raddr[3*AW +: AW] = AW'(32'h333);
        bus.i_raddr[1*AW +: AW] = AW'(32'h111);
        bus.i_rdata_req = 4'b1000;
        bus.i_rdata_req_accepted = 1'b1;
        step();
        checks++; if (bus.o_rdata_req !== 1'b1 || bus.o_raddr !== AW'(32'h333)) begin failures++; $display("FAIL order_issue3 got=%0b/%h want=1/333", bus.o_rdata_req, bus.o_raddr); end
        step();
        checks++; if (bus.o_rdata_req_accepted !== 4'b1000) begin failures++; $display("FAIL order_acc3 got=%b want=1000", bus.o_rdata_req_accepted); end
        bus.i_rdata_req = 4'b0010;
        step();
        step();
        checks++; if (bus.o_rdata_req !== 1'b1 || bus.o_raddr !== AW'(32'h111)) begin failures++; $display("FAIL order_issue1 got=%0b/%h want=1/111", bus.o_rdata_req, bus.o_raddr); end
        step();
        checks++; if (bus.o_rdata_req_accepted !== 4'b0010) begin failures++; $display("FAIL order_acc1 got=%b want=0010", bus.o_rdata_req_accepted); end
        bus.i_rdata_req = '0;
        bus.i_rdata_req_accepted = 1'b0;
        for (int w = 0; w < 4; w++) begin
            bus.i_rdata_valid    = 1'b1;
            bus.i_rdata          = DW'(64'h50 + w);
            bus.i_rdata_lastword = (w == 1 || w == 3);
            step();
            checks++; if (bus.o_rdata_valid !== ((w < 2) ? 4'b1000 : 4'b0010)) begin failures++; $display("FAIL order_vld w%0d got=%b want=%b", w, bus.o_rdata_valid, (w < 2) ? 4'b1000 : 4'b0010); end
            checks++; if (bus.o_rdata !== DW'(64'h50 + w)) begin failures++; $display("FAIL order_data w%0d got=%h want=%h", w, bus.o_rdata, 64'h50 + w); end
        end
        bus.i_rdata_valid    = 1'b0;
        bus.i_rdata_lastword = 1'b0;
        step();
        checks++; if (bus.o_rdata_valid !== 4'b0000) begin failures++; $display("FAIL order_end got=%b want=0000", bus.o_rdata_valid); end
    endtask

    task automatic test_err_reset();
        do_reset();
        bus.i_rdata_valid = 1'b1;
        bus.i_rdata       = DW'(64'hDEAD);
        step();
        checks++; if (bus.o_rdata_valid !== 4'b0000) begin failures++; $display("FAIL err_no_vld got=%b want=0000", bus.o_rdata_valid); end
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_set got=%0b want=1", err); end
        bus.i_rdata_valid = 1'b0;
        step();
        step();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b want=1", err); end
        bus.i_rdata_req = 4'b0001;
        bus.i_rdata_req_accepted = 1'b1;
        step();
        step();
        bus.i_rdata_req = '0;
        bus.i_rdata_req_accepted = 1'b0;
        step();
        checks++; if (dut.outstanding_q !== 3'd1) begin failures++; $display("FAIL err_outstanding got=%0d want=1", dut.outstanding_q); end
        bus.i_raddr[2*AW +: AW] = AW'(32'h77);
        bus.i_rdata_req = 4'b0100;
        step();
        checks++; if (bus.o_rdata_req !== 1'b1) begin failures++; $display("FAIL err_issue got=%0b want=1", bus.o_rdata_req); end
        rst = 1'b1;
        step();
        checks++; if (bus.o_rdata_req !== 1'b0 || bus.o_raddr !== '0 || bus.o_rdata_req_accepted !== '0) begin failures++; $display("FAIL rst_mid_req got=%0b/%h/%b want=0/0/0", bus.o_rdata_req, bus.o_raddr, bus.o_rdata_req_accepted); end
        checks++; if (bus.o_rdata_valid !== '0 || bus.o_rdata !== '0) begin failures++; $display("FAIL rst_mid_data got=%b/%h want=0/0", bus.o_rdata_valid, bus.o_rdata); end
        checks++; if (err !== 1'b0 || stall !== 32'd0) begin failures++; $display("FAIL rst_mid_err got=%0b/%0d want=0/0", err, stall); end
        checks++; if (dut.outstanding_q !== '0 || dut.rr_ptr_q !== '0 || int'(dut.state_q) != 0) begin failures++; $display("FAIL rst_mid_state got=%0d/%0d/%0d want=0/0/0", dut.outstanding_q, dut.rr_ptr_q, int'(dut.state_q)); end
        rst = 1'b0;
        bus.i_rdata_req = '0;
        bus.i_rdata_valid = 1'b1;
        bus.i_rdata_lastword = 1'b1;
        step();
        checks++; if (bus.o_rdata_valid !== 4'b0000 || err !== 1'b1) begin failures++; $display("FAIL rst_late_data got=%b/%0b want=0000/1", bus.o_rdata_valid, err); end
        clear_inputs();
        step();
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single();
        test_fairness();
        test_credit();
        test_order();
        test_err_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
